pid_duty_compensator: RTL and testbench

- Sequential incremental-form digital PID compensator; sits directly upstream of the counter-based DPWM.
- Once per ADC sample it computes the voltage error and runs a three-tap difference equation on a single shared multiplier.
- It clamps the result for anti-windup and presents a registered 9-bit duty command that the DPWM compares against its free-running counter.
- One computation per switching period; latency of a few clocks.

---
 rtl/pid_duty_compensator.sv | 180 ++++++++++++++++++
 tb/tb_pid_duty_compensator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pid_duty_compensator.sv
`default_nettype none
// ============================================================================
//  Module   : pid_duty_compensator
//  Purpose  : Incremental-form digital PID compensator feeding a counter-based
//             DPWM. For each accepted ADC sample it forms the voltage error,
//             evaluates u[n] = u[n-1] + K0*e[n] + K1*e[n-1] + K2*e[n-2] on one
//             time-shared multiplier, clamps the duty state (anti-windup), and
//             presents a registered 9-bit duty command.
//  Ports    : clk        - system clock (shared with the DPWM), rising edge
//             rst        - asynchronous reset, active low (0 = reset)
//             adc_data   - unsigned 8-bit output-voltage sample
//             adc_valid  - one-cycle strobe qualifying adc_data
//             vref       - unsigned 8-bit reference, captured with adc_data
//             d_n        - registered duty command to the DPWM
//             d_valid    - one-cycle pulse when d_n updates
//             busy       - high while a computation is in progress
//             overrun    - one-cycle pulse when a sample is dropped
//  Revision : 1.0 - initial release
// ============================================================================
module pid_duty_compensator #(
    parameter logic signed [11:0] K0        = 12'sd24,
    parameter logic signed [11:0] K1        = -12'sd32,
    parameter logic signed [11:0] K2        = 12'sd10,
    parameter int                 FRAC      = 4,
    parameter int                 DUTY_INIT = 256,
    parameter int                 DUTY_MIN  = 8,
    parameter int                 DUTY_MAX  = 460
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] adc_data,
    input  logic       adc_valid,
    input  logic [7:0] vref,
    output logic [8:0] d_n,
    output logic       d_valid,
    output logic       busy,
    output logic       overrun
);

    // Duty state carries 9 integer bits plus FRAC fractional bits.
    localparam int                 c_UW    = 9 + FRAC;
    localparam logic signed [25:0] c_UMIN  = 26'(DUTY_MIN * (2 ** FRAC));
    localparam logic signed [25:0] c_UMAX  = 26'(DUTY_MAX * (2 ** FRAC));
    localparam logic [c_UW-1:0]    c_UINIT = c_UW'(DUTY_INIT * (2 ** FRAC));

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MAC0   = 3'd1,
        S_MAC1   = 3'd2,
        S_MAC2   = 3'd3,
        S_SAT    = 3'd4,
        S_UPDATE = 3'd5
    } state_t;

    state_t                   state_q;
    logic signed [8:0]        e_reg_q;
    logic signed [8:0]        e1_q;
    logic signed [8:0]        e2_q;
    logic signed [23:0]       acc_q;
    logic        [c_UW-1:0]   u_q;
    logic        [8:0]        d_n_q;
    logic                     d_valid_q;
    logic                     busy_q;
    logic                     overrun_q;

    // ------------------------------------------------------------------
    // Shared multiplier: operands are steered by the current MAC state.
    // ------------------------------------------------------------------
    logic signed [11:0] mul_coef;
    logic signed [8:0]  mul_err;
    logic signed [20:0] prod;
    logic signed [23:0] prod_ext;
    logic signed [23:0] acc_d;

    always_comb begin
        mul_coef = K0;
        mul_err  = e_reg_q;
        case (state_q)
            S_MAC1: begin
                mul_coef = K1;
                mul_err  = e1_q;
            end
            S_MAC2: begin
                mul_coef = K2;
                mul_err  = e2_q;
            end
            default: ;
        endcase
    end

    assign prod     = $signed({{9{mul_coef[11]}}, mul_coef}) * $signed({{12{mul_err[8]}}, mul_err});
    assign prod_ext = {{3{prod[20]}}, prod};
    // MAC0 starts a fresh accumulation; MAC1/MAC2 add onto it.
    assign acc_d    = (state_q == S_MAC0) ? prod_ext : (acc_q + prod_ext);

    // ------------------------------------------------------------------
    // Saturating update of the duty state. Clamping u itself is what
    // prevents windup: there is no other integrator to unwind.
    // ------------------------------------------------------------------
    logic signed [25:0] sum;
    logic [c_UW-1:0]    u_d;

    assign sum = $signed({{2{acc_q[23]}}, acc_q}) + $signed({{(26 - c_UW){1'b0}}, u_q});

    always_comb begin
        u_d = sum[c_UW-1:0];
        if (sum < c_UMIN) begin
            u_d = c_UMIN[c_UW-1:0];
        end else if (sum > c_UMAX) begin
            u_d = c_UMAX[c_UW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer and all state registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            e_reg_q   <= '0;
            e1_q      <= '0;
            e2_q      <= '0;
            acc_q     <= '0;
            u_q       <= c_UINIT;
            d_n_q     <= 9'(DUTY_INIT);
            d_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            d_valid_q <= 1'b0;
            // A strobe outside IDLE (including the UPDATE cycle) is dropped.
            overrun_q <= adc_valid && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (adc_valid) begin
                        e_reg_q <= $signed({1'b0, vref}) - $signed({1'b0, adc_data});
                        busy_q  <= 1'b1;
                        state_q <= S_MAC0;
                    end
                end
                S_MAC0: begin
                    acc_q   <= acc_d;
                    state_q <= S_MAC1;
                end
                S_MAC1: begin
                    acc_q   <= acc_d;
                    state_q <= S_MAC2;
                end
                S_MAC2: begin
                    acc_q   <= acc_d;
                    state_q <= S_SAT;
                end
                S_SAT: begin
                    u_q     <= u_d;
                    state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    // u is never negative, so dropping fraction bits is floor.
                    d_n_q     <= u_q[FRAC +: 9];
                    d_valid_q <= 1'b1;
                    e2_q      <= e1_q;
                    e1_q      <= e_reg_q;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign d_n     = d_n_q;
    assign d_valid = d_valid_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pid_duty_compensator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pid_duty_compensator
//  Purpose  : Scoreboard bench for pid_duty_compensator. Stimulus pushes the
//             expected duty value and arrival cycle; a monitor thread pops
//             and compares on every d_valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pid_duty_compensator;

    logic       clk;
    logic       rst;
    logic [7:0] adc_data;
    logic       adc_valid;
    logic [7:0] vref;
    logic [8:0] d_n;
    logic       d_valid;
    logic       busy;
    logic       overrun;

    pid_duty_compensator dut (
        .clk       (clk),
        .rst       (rst),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .vref      (vref),
        .d_n       (d_n),
        .d_valid   (d_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        int at;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pops one expectation per d_valid pulse; checks value and arrival cycle.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (d_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_d_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("d_n", int'(d_n), e.d);
                    chk("d_valid_latency", cyc, e.at);
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            vref      = 8'($urandom);
            adc_data  = 8'($urandom);
            adc_valid = 1'($urandom);
            @(negedge clk);
            chk("rst_d_n", int'(d_n), 256);
            chk("rst_d_valid", int'(d_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_overrun", int'(overrun), 0);
        end
        adc_valid = 1'b0;
        rst       = 1'b1;
    endtask

    // Issues one sample at the next falling edge. Acceptance happens on the
    // following rising edge; d_valid is expected five edges later.
    task automatic send(input logic [7:0] v, input logic [7:0] a, input int exp_d, input bit push);
        @(negedge clk);
        vref      = v;
        adc_data  = a;
        adc_valid = 1'b1;
        if (push) q.push_back('{exp_d, cyc + 6});
        @(negedge clk);
        adc_valid = 1'b0;
        vref      = 8'($urandom);
        adc_data  = 8'($urandom);
        chk("busy_after_accept", int'(busy), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    int step_exp[3] = '{271, 266, 267};
    int sat_exp[8]  = '{460, 332, 364, 396, 428, 460, 460, 460};

    initial begin
        int ovr_cnt;
        rst       = 1'b0;
        adc_valid = 1'b0;
        vref      = 8'd0;
        adc_data  = 8'd0;
        fork
            monitor();
        join_none

        // Reset values held with random inputs.
        do_reset(6);

        // Zero error: duty holds, spaced one PWM period apart.
        for (int i = 0; i < 10; i++) begin
            send(8'd128, 8'd128, 256, 1'b1);
            repeat (510) @(negedge clk);
        end
        drain();
        chk("zero_err_hold", int'(d_n), 256);

        // Step response, e = 10.
        do_reset(3);
        for (int i = 0; i < 3; i++) begin
            send(8'd128, 8'd118, step_exp[i], 1'b1);
            repeat (8) @(negedge clk);
        end
        drain();

        // Saturation high, then immediate recovery to the low clamp.
        do_reset(3);
        for (int i = 0; i < 8; i++) begin
            send(8'd255, 8'd0, sat_exp[i], 1'b1);
            repeat (6) @(negedge clk);
        end
        send(8'd0, 8'd255, 8, 1'b1);
        repeat (6) @(negedge clk);
        drain();

        // Overrun: second strobe two clocks after the first is dropped.
        do_reset(3);
        @(negedge clk);
        vref      = 8'd128;
        adc_data  = 8'd118;
        adc_valid = 1'b1;
        q.push_back('{271, cyc + 6});
        @(negedge clk);
        adc_valid = 1'b0;
        @(negedge clk);
        chk("overrun_early", int'(overrun), 0);
        adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        chk("overrun_pulse", int'(overrun), 1);
        ovr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (overrun) ovr_cnt++;
        end
        chk("overrun_extra_pulses", ovr_cnt, 0);
        drain();

        // Reset in MAC1 discards the computation and clears history.
        do_reset(3);
        @(negedge clk);
        vref      = 8'd128;
        adc_data  = 8'd118;
        adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midop_busy", int'(busy), 0);
        chk("midop_d_n", int'(d_n), 256);
        chk("midop_d_valid", int'(d_valid), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send(8'd128, 8'd118, 271, 1'b1);
        repeat (8) @(negedge clk);
        drain();
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute watchdog so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
